regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer (ROB).
- Consumes ROB nick allocations (rename) and ROB commits (write-back), and serves registered operand reads to dispatch.
- On a ROB clear (mispredict), drops all pending renames so that dispatch sees only committed state.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- NICK_W, 5, ROB nick width; nick 0 means "no producer"; valid nicks are 1..31.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; when low the block stalls
- clr  in  1  ROB flush
- iROB_nick_en  in  1  rename request
- iROB_nick  in  NICK_W  nick allocated to the new producer
- iROB_nick_regnm  in  5  destination register of the new producer
- iROB_en  in  1  commit request
- iROB_rd_regnm  in  5  committed destination register
- iROB_rd_dt  in  DATA_W  committed value
- iROB_rd_nick  in  NICK_W  nick of the committing entry
- iDP_en  in  1  operand read request
- iDP_rs1  in  5  source register 1
- iDP_rs2  in  5  source register 2
- oDP_en  out  1  read result valid
- oDP_rs1_dt  out  DATA_W  rs1 value (meaningful when not busy)
- oDP_rs1_busy  out  1  rs1 still pending
- oDP_rs1_nick  out  NICK_W  rs1 producer nick (0 when not busy)
- oDP_rs2_dt, oDP_rs2_busy, oDP_rs2_nick  out  DATA_W, 1, NICK_W  same fields for rs2

Behaviour:
- Reset (async, on assertion):
  - All values, busy bits and nicks are set to 0.
  - All outputs are 0, oDP_en is 0.
- rdy low: no state change; outputs hold their current values.
- Rename (iROB_nick_en, regnm != 0): at the posedge, busy[regnm] <= 1 and nick[regnm] <= iROB_nick. A rename to x0 is ignored.
- Commit (iROB_en, regnm != 0):
  - val[regnm] <= iROB_rd_dt.
  - busy[regnm] is cleared only if nick[regnm] == iROB_rd_nick; otherwise a younger rename is pending and busy stays set.
  - Commit to x0 is ignored.
- Same-cycle rename and commit to the same register: the value is written; busy/nick take the rename (busy = 1, new nick).
- clr: all busy bits <= 0 and all nicks <= 0; values are kept. A commit in the same cycle still writes its value. A rename in the same cycle is discarded.
- Read, 1-cycle latency: an iDP_en sample at edge N produces oDP_en = 1 and data valid after edge N; oDP_en = 0 otherwise.
  - Reads use state before the same-cycle rename, so an instruction with rs == rd sees the older producer.
  - Commit bypass: if the same-cycle commit targets rsX and its nick equals nick[rsX], output the committed data with busy = 0 and nick = 0.
  - If clr is high in the read cycle, outputs show busy = 0 for all sources and data = committed value (post-commit).
  - rsX == 0 always gives data 0, busy 0, nick 0.
- No backpressure: one read, one rename and one commit can be accepted every cycle.

Optional Feature:
- Macro: RF_STAT_EN.
- When defined: adds outputs oSTAT_commit_cnt (32-bit) and oSTAT_flush_cnt (32-bit).
  - oSTAT_commit_cnt increments on each commit with rdy high, including commits to x0.
  - oSTAT_flush_cnt increments on each clr with rdy high.
  - Both wrap modulo 2^32 and reset to 0.
- When not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Rename x5 to nick 3, then read x5 → busy = 1, nick = 3. Commit x5 = 0xDEADBEEF with nick 3, then read → busy = 0, data 0xDEADBEEF.
- Rename x7 to nick 4, then rename x7 to nick 9, then commit x7 = 0x11 with nick 4 → data 0x11 stored, read gives busy = 1, nick = 9.
- Read x5 in the same cycle as the commit of x5 with matching nick 3 (data 0xA5) → oDP_rs1_dt = 0xA5, busy = 0, nick = 0 (bypass).
- Rename x1 to nick 2 and x2 to nick 6, then assert clr with a same-cycle commit of x3 = 0x42 → reads show x1/x2 not busy with old values, x3 = 0x42.
- Rename x0, then commit x0 = 0xFFFF → read x0 gives 0, busy = 0. Deassert rdy for 3 cycles with requests present → no state change, outputs held.
- Assert rst asynchronously mid-stream with x5 busy → outputs 0 immediately and all busy bits clear. With RF_STAT_EN: 5 commits and 2 clr → counters read 5 and 2.

Source files
------------

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - rename-tagged architectural register file with registered dispatch reads
// Optional commit/flush statistics counters are built when RF_STAT_EN is defined.
module regfile_rename #(
    parameter int REG_NUM = 32,
    parameter int NICK_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [4:0]        iROB_nick_regnm,
    input  logic              iROB_en,
    input  logic [4:0]        iROB_rd_regnm,
    input  logic [DATA_W-1:0] iROB_rd_dt,
    input  logic [NICK_W-1:0] iROB_rd_nick,
    input  logic              iDP_en,
    input  logic [4:0]        iDP_rs1,
    input  logic [4:0]        iDP_rs2,
    output logic              oDP_en,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic              oDP_rs1_busy,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [DATA_W-1:0] oDP_rs2_dt,
    output logic              oDP_rs2_busy,
    output logic [NICK_W-1:0] oDP_rs2_nick
`ifdef RF_STAT_EN
    ,
    output logic [31:0]       oSTAT_commit_cnt,
    output logic [31:0]       oSTAT_flush_cnt
`endif
);

    logic [DATA_W-1:0] r_val  [REG_NUM];
    logic [NICK_W-1:0] r_nick [REG_NUM];
    logic [REG_NUM-1:0] r_busy;

    logic [4:0]        w_rs      [2];
    logic              w_cmt_hit [2];
    logic [DATA_W-1:0] w_dt      [2];
    logic              w_busy    [2];
    logic [NICK_W-1:0] w_nick    [2];

    assign w_rs[0] = iDP_rs1;
    assign w_rs[1] = iDP_rs2;

    // Operand lookup sees pre-rename state, with the same-cycle commit forwarded.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_cmt_hit[p] = iROB_en && (iROB_rd_regnm == w_rs[p]);
            w_dt[p]      = '0;
            w_busy[p]    = 1'b0;
            w_nick[p]    = '0;
            if (w_rs[p] != 5'd0) begin
                if (clr) begin
                    w_dt[p] = w_cmt_hit[p] ? iROB_rd_dt : r_val[w_rs[p]];
                end else if (w_cmt_hit[p] && (iROB_rd_nick == r_nick[w_rs[p]])) begin
                    w_dt[p] = iROB_rd_dt;
                end else begin
                    w_dt[p]   = r_val[w_rs[p]];
                    w_busy[p] = r_busy[w_rs[p]];
                    w_nick[p] = r_busy[w_rs[p]] ? r_nick[w_rs[p]] : '0;
                end
            end
        end
    end

    // Rename beats a same-cycle commit for busy/nick; a flush beats both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_val[i]  <= '0;
                r_nick[i] <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (iROB_en && (iROB_rd_regnm == 5'(i))) begin
                    r_val[i] <= iROB_rd_dt;
                end
                if (clr) begin
                    r_busy[i] <= 1'b0;
                    r_nick[i] <= '0;
                end else if (iROB_nick_en && (iROB_nick_regnm == 5'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_nick[i] <= iROB_nick;
                end else if (iROB_en && (iROB_rd_regnm == 5'(i)) && (r_nick[i] == iROB_rd_nick)) begin
                    r_busy[i] <= 1'b0;
                    r_nick[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oDP_en       <= 1'b0;
            oDP_rs1_dt   <= '0;
            oDP_rs1_busy <= 1'b0;
            oDP_rs1_nick <= '0;
            oDP_rs2_dt   <= '0;
            oDP_rs2_busy <= 1'b0;
            oDP_rs2_nick <= '0;
        end else if (rdy) begin
            oDP_en <= iDP_en;
            if (iDP_en) begin
                oDP_rs1_dt   <= w_dt[0];
                oDP_rs1_busy <= w_busy[0];
                oDP_rs1_nick <= w_nick[0];
                oDP_rs2_dt   <= w_dt[1];
                oDP_rs2_busy <= w_busy[1];
                oDP_rs2_nick <= w_nick[1];
            end
        end
    end

`ifdef RF_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oSTAT_commit_cnt <= '0;
            oSTAT_flush_cnt  <= '0;
        end else if (rdy) begin
            if (iROB_en) begin
                oSTAT_commit_cnt <= oSTAT_commit_cnt + 32'd1;
            end
            if (clr) begin
                oSTAT_flush_cnt <= oSTAT_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - directed scoreboard bench for regfile_rename
module tb_regfile_rename;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick;
    logic [4:0]  iROB_nick_regnm;
    logic        iROB_en;
    logic [4:0]  iROB_rd_regnm;
    logic [31:0] iROB_rd_dt;
    logic [4:0]  iROB_rd_nick;
    logic        iDP_en;
    logic [4:0]  iDP_rs1;
    logic [4:0]  iDP_rs2;
    logic        oDP_en;
    logic [31:0] oDP_rs1_dt;
    logic        oDP_rs1_busy;
    logic [4:0]  oDP_rs1_nick;
    logic [31:0] oDP_rs2_dt;
    logic        oDP_rs2_busy;
    logic [4:0]  oDP_rs2_nick;
`ifdef RF_STAT_EN
    logic [31:0] oSTAT_commit_cnt;
    logic [31:0] oSTAT_flush_cnt;
`endif

    regfile_rename dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clr             (clr),
        .iROB_nick_en    (iROB_nick_en),
        .iROB_nick       (iROB_nick),
        .iROB_nick_regnm (iROB_nick_regnm),
        .iROB_en         (iROB_en),
        .iROB_rd_regnm   (iROB_rd_regnm),
        .iROB_rd_dt      (iROB_rd_dt),
        .iROB_rd_nick    (iROB_rd_nick),
        .iDP_en          (iDP_en),
        .iDP_rs1         (iDP_rs1),
        .iDP_rs2         (iDP_rs2),
        .oDP_en          (oDP_en),
        .oDP_rs1_dt      (oDP_rs1_dt),
        .oDP_rs1_busy    (oDP_rs1_busy),
        .oDP_rs1_nick    (oDP_rs1_nick),
        .oDP_rs2_dt      (oDP_rs2_dt),
        .oDP_rs2_busy    (oDP_rs2_busy),
        .oDP_rs2_nick    (oDP_rs2_nick)
`ifdef RF_STAT_EN
        ,
        .oSTAT_commit_cnt(oSTAT_commit_cnt),
        .oSTAT_flush_cnt (oSTAT_flush_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] d1;
        logic        b1;
        logic [4:0]  n1;
        logic [31:0] d2;
        logic        b2;
        logic [4:0]  n2;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr          = 1'b0;
        iROB_nick_en = 1'b0;
        iROB_nick    = '0;
        iROB_nick_regnm = '0;
        iROB_en      = 1'b0;
        iROB_rd_regnm = '0;
        iROB_rd_dt   = '0;
        iROB_rd_nick = '0;
        iDP_en       = 1'b0;
        iDP_rs1      = '0;
        iDP_rs2      = '0;
    endtask

    task automatic ren(input logic [4:0] r, input logic [4:0] n);
        iROB_nick_en    = 1'b1;
        iROB_nick_regnm = r;
        iROB_nick       = n;
    endtask

    task automatic cmt(input logic [4:0] r, input logic [31:0] d, input logic [4:0] n);
        iROB_en       = 1'b1;
        iROB_rd_regnm = r;
        iROB_rd_dt    = d;
        iROB_rd_nick  = n;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] d1, input logic b1, input logic [4:0] n1,
                      input logic [31:0] d2, input logic b2, input logic [4:0] n2);
        exp_t e;
        iDP_en  = 1'b1;
        iDP_rs1 = a;
        iDP_rs2 = b;
        e.tag = tag; e.d1 = d1; e.b1 = b1; e.n1 = n1; e.d2 = d2; e.b2 = b2; e.n2 = n2;
        exp_q.push_back(e);
    endtask

    // Advance one cycle; pop and compare the scoreboard when a read was accepted.
    task automatic tick();
        logic issued;
        logic was_rdy;
        exp_t e;
        issued  = iDP_en && rdy && !rst;
        was_rdy = rdy && !rst;
        @(posedge clk);
        #1;
        if (issued) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_en"},      32'(oDP_en),       32'd1);
                chk({e.tag, "_rs1_dt"},  oDP_rs1_dt,        e.d1);
                chk({e.tag, "_rs1_bsy"}, 32'(oDP_rs1_busy), 32'(e.b1));
                chk({e.tag, "_rs1_nk"},  32'(oDP_rs1_nick), 32'(e.n1));
                chk({e.tag, "_rs2_dt"},  oDP_rs2_dt,        e.d2);
                chk({e.tag, "_rs2_bsy"}, 32'(oDP_rs2_busy), 32'(e.b2));
                chk({e.tag, "_rs2_nk"},  32'(oDP_rs2_nick), 32'(e.n2));
            end
        end else if (was_rdy) begin
            chk("en_idle", 32'(oDP_en), 32'd0);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        #1;
        chk("rst_en",     32'(oDP_en),       32'd0);
        chk("rst_rs1_dt", oDP_rs1_dt,        32'd0);
        chk("rst_rs2_nk", 32'(oDP_rs2_nick), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        tick();

        // Rename then commit with matching nick.
        ren(5, 3); tick();
        rd("busy_x5", 5, 0, 32'h0, 1, 3, 32'h0, 0, 0); tick();
        cmt(5, 32'hDEADBEEF, 3); tick();
        rd("cmt_x5", 5, 0, 32'hDEADBEEF, 0, 0, 32'h0, 0, 0); tick();

        // Stale commit leaves the younger rename pending.
        ren(7, 4); tick();
        ren(7, 9); tick();
        cmt(7, 32'h11, 4); tick();
        rd("stale_x7", 7, 5, 32'h11, 1, 9, 32'hDEADBEEF, 0, 0); tick();

        // Commit bypass into a same-cycle read.
        ren(5, 3); tick();
        cmt(5, 32'hA5, 3);
        rd("bypass_x5", 5, 7, 32'hA5, 0, 0, 32'h11, 1, 9); tick();
        rd("after_byp", 5, 0, 32'hA5, 0, 0, 32'h0, 0, 0); tick();

        // rs == rd sees the older producer.
        ren(9, 5);
        rd("rs_eq_rd", 9, 7, 32'h0, 0, 0, 32'h11, 1, 9); tick();
        rd("x9_busy", 9, 0, 32'h0, 1, 5, 32'h0, 0, 0); tick();

        // Same-cycle rename and commit to one register.
        ren(7, 12);
        cmt(7, 32'h22, 9); tick();
        rd("ren_cmt_x7", 7, 0, 32'h22, 1, 12, 32'h0, 0, 0); tick();

        // Flush with same-cycle commit and discarded rename.
        cmt(1, 32'h100, 0); tick();
        cmt(2, 32'h200, 0); tick();
        ren(1, 2); tick();
        ren(2, 6); tick();
        rd("pre_clr", 1, 2, 32'h100, 1, 2, 32'h200, 1, 6); tick();
        clr = 1'b1;
        cmt(3, 32'h42, 7);
        ren(4, 8);
        rd("clr_cycle", 3, 1, 32'h42, 0, 0, 32'h100, 0, 0); tick();
        rd("post_clr_a", 2, 4, 32'h200, 0, 0, 32'h0, 0, 0); tick();
        rd("post_clr_b", 7, 9, 32'h22, 0, 0, 32'h0, 0, 0); tick();

        // x0 is hardwired.
        ren(0, 3); tick();
        cmt(0, 32'hFFFF, 3); tick();
        rd("x0", 0, 0, 32'h0, 0, 0, 32'h0, 0, 0); tick();
        rd("x3", 3, 0, 32'h42, 0, 0, 32'h0, 0, 0); tick();

        // Stall: requests present but rdy low.
        rd("pre_stall", 5, 3, 32'hA5, 0, 0, 32'h42, 0, 0); tick();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ren(5, 10);
            cmt(6, 32'h66, 0);
            iDP_en = 1'b1; iDP_rs1 = 6; iDP_rs2 = 6;
            tick();
            chk("stall_en",     32'(oDP_en),       32'd1);
            chk("stall_rs1_dt", oDP_rs1_dt,        32'hA5);
            chk("stall_rs2_dt", oDP_rs2_dt,        32'h42);
            chk("stall_rs1_bs", 32'(oDP_rs1_busy), 32'd0);
        end
        rdy = 1'b1;
        rd("post_stall", 5, 6, 32'hA5, 0, 0, 32'h0, 0, 0); tick();

        // Asynchronous reset mid-cycle.
        ren(5, 11); tick();
        rd("pre_rst", 5, 7, 32'hA5, 1, 11, 32'h22, 0, 0); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en",      32'(oDP_en),       32'd0);
        chk("arst_rs1_dt",  oDP_rs1_dt,        32'd0);
        chk("arst_rs1_bsy", 32'(oDP_rs1_busy), 32'd0);
        chk("arst_rs1_nk",  32'(oDP_rs1_nick), 32'd0);
        chk("arst_rs2_dt",  oDP_rs2_dt,        32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        rd("post_rst", 5, 7, 32'h0, 0, 0, 32'h0, 0, 0); tick();

`ifdef RF_STAT_EN
        chk("stat_rst_cmt", oSTAT_commit_cnt, 32'd0);
        cmt(1, 32'h1, 0); tick();
        cmt(0, 32'h2, 0); tick();
        cmt(2, 32'h3, 0); tick();
        clr = 1'b1; cmt(3, 32'h4, 0); tick();
        clr = 1'b1; tick();
        cmt(4, 32'h5, 0); tick();
        rdy = 1'b0;
        clr = 1'b1; cmt(5, 32'h6, 0); tick();
        rdy = 1'b1;
        chk("stat_commit", oSTAT_commit_cnt, 32'd5);
        chk("stat_flush",  oSTAT_flush_cnt,  32'd2);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
